// File: rtl/mux_pkg.sv
// Shared constants and the select-width helper for the stream mux family.
package mux_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_CHANNELS = 4;

   // Ceiling log2 with a floor of one bit, so a 1-wide select still exists.
   function automatic int sel_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted channel.
// Grant is combinational from req and ptr; ptr advances only when update is high.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   localparam int SEL_W = sel_width(CHANNELS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] req,
   input  logic                update,
   output logic [SEL_W-1:0]    grant,
   output logic                grant_vld
);

   logic [SEL_W-1:0] ptr;
   int idx;

   always_comb begin
      grant     = '0;
      grant_vld = 1'b0;
      idx       = 0;
      for (int k = 1; k <= CHANNELS; k++) begin
         idx = (int'(ptr) + k) % CHANNELS;
         if (!grant_vld && req[idx]) begin
            grant     = SEL_W'(idx);
            grant_vld = 1'b1;
         end
      end
   end

   // Reset to the last channel so channel 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= SEL_W'(CHANNELS - 1);
      else if (update)
         ptr <= grant;
   end

endmodule

// File: rtl/stream_mux_n.sv
// Registered N:1 stream mux with valid/ready on every port; 1-cycle latency.
// Selection is external (sel) by default, or round-robin when STREAM_MUX_RR_EN is defined.
module stream_mux_n
   import mux_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   localparam int SEL_W = sel_width(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SEL_W-1:0]          out_chan
);

   logic             load_en;
   logic             cand_vld;
   logic             xfer;
   logic [SEL_W-1:0] cand;
   logic [WIDTH-1:0] cand_data;

   assign load_en = !out_valid || out_ready;

`ifdef STREAM_MUX_RR_EN
   logic unused_sel;
   assign unused_sel = ^sel;

   rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (in_valid),
      .update    (xfer),
      .grant     (cand),
      .grant_vld (cand_vld)
   );
`else
   // Out-of-range selects (non-power-of-2 CHANNELS) name no channel.
   assign cand     = sel;
   assign cand_vld = (32'(sel) < 32'(CHANNELS));
`endif

   always_comb begin
      in_ready  = '0;
      cand_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (32'(cand) == 32'(i)) begin
            cand_data   = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = !rst && load_en && cand_vld;
         end
      end
   end

   assign xfer = |(in_valid & in_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= cand_data;
         out_chan  <= cand;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
